// File: rtl/nanov_fetch_seq.sv
// nanov_fetch_seq: SPI flash instruction fetch and bit-serial sequencer
// feeding nanoV_core; the next word streams in during the final 32-clk cycle.
//
// Ports:
//   clk, rstn        core clock, async active-low reset
//   spi_miso         flash data in, sampled on posedge clk
//   spi_select       flash chip select (active low)
//   spi_clk_en       gate enable for flash SCK
//   spi_mosi         command/address bit to flash
//   instr            current instruction (NOP outside EXEC)
//   cycle, counter   instruction cycle index and bit index within it
//   pc               serial pc bit, pc_reg[counter]
//   branch           branch request from core, honoured only at cycle 0
//   branch_target    new pc, sampled at the end of the branching instruction
module nanov_fetch_seq #(
    parameter int          ADDR_BITS = 24,
    parameter logic [7:0]  READ_CMD  = 8'h03,
    parameter logic [31:0] PC_RESET  = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        spi_miso,
    output logic        spi_select,
    output logic        spi_clk_en,
    output logic        spi_mosi,
    output logic [31:0] instr,
    output logic [2:0]  cycle,
    output logic [4:0]  counter,
    output logic        pc,
    input  logic        branch,
    input  logic [31:0] branch_target
);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [4:0]  ALAST = 5'(ADDR_BITS - 1);

    typedef enum logic [2:0] {DESEL, CMD, ADDR, FILL, EXEC} state_t;

    state_t      state_q, state_d;
    logic [4:0]  bcnt;
    logic [31:0] pc_reg;
    logic [31:0] sr;
    logic        br_pend;

    logic [31:0] nxt;
    logic [31:0] word;
    logic        is_jal;
    logic        is_shift;
    logic        last_cyc;
    logic        take;
    logic [2:0]  cidx;
    logic [4:0]  aidx;

    // Flash delivers byte0 first, MSB first; swap into a little-endian word.
    assign nxt  = {sr[30:0], spi_miso};
    assign word = {nxt[7:0], nxt[15:8], nxt[23:16], nxt[31:24]};

    assign is_jal   = (instr[6:0] == 7'b1101111);
    assign is_shift = ((instr[6:0] == 7'b0010011) ||
                       (instr[6:0] == 7'b0110011)) &&
                      (instr[13:12] == 2'b01);
    assign last_cyc = (cycle == {2'b00, is_jal | is_shift});
    // A branch raised on the last clk of a 1-cycle instruction still counts.
    assign take     = br_pend | (branch && (cycle == 3'd0));

    assign cidx = 3'd7 - bcnt[2:0];
    assign aidx = ALAST - bcnt;
    assign pc   = pc_reg[counter];

    always_comb begin
        state_d    = state_q;
        spi_select = 1'b1;
        spi_clk_en = 1'b0;
        spi_mosi   = 1'b0;
        unique case (state_q)
            DESEL: begin
                state_d = CMD;
            end
            CMD: begin
                spi_select = 1'b0;
                spi_clk_en = 1'b1;
                spi_mosi   = READ_CMD[cidx];
                if (bcnt == 5'd7) state_d = ADDR;
            end
            ADDR: begin
                spi_select = 1'b0;
                spi_clk_en = 1'b1;
                spi_mosi   = pc_reg[aidx];
                if (bcnt == ALAST) state_d = FILL;
            end
            FILL: begin
                spi_select = 1'b0;
                spi_clk_en = 1'b1;
                if (bcnt == 5'd31) state_d = EXEC;
            end
            EXEC: begin
                spi_select = 1'b0;
                // Flash stalls with CS low during non-final cycles.
                spi_clk_en = last_cyc;
                if (counter == 5'd31 && last_cyc && take) state_d = DESEL;
            end
            default: state_d = DESEL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DESEL;
            bcnt    <= 5'd0;
            pc_reg  <= PC_RESET;
            sr      <= 32'd0;
            br_pend <= 1'b0;
            instr   <= NOP;
            cycle   <= 3'd0;
            counter <= 5'd0;
        end else begin
            state_q <= state_d;
            bcnt    <= (state_d != state_q) ? 5'd0 : bcnt + 5'd1;
            if (spi_clk_en && (state_q == FILL || state_q == EXEC))
                sr <= nxt;
            if (state_q == FILL && bcnt == 5'd31) begin
                instr   <= word;
                counter <= 5'd0;
                cycle   <= 3'd0;
            end else if (state_q == EXEC) begin
                counter <= counter + 5'd1;
                if (branch && cycle == 3'd0)
                    br_pend <= 1'b1;
                if (counter == 5'd31) begin
                    if (!last_cyc) begin
                        cycle <= cycle + 3'd1;
                    end else if (take) begin
                        pc_reg  <= branch_target;
                        br_pend <= 1'b0;
                        instr   <= NOP;
                        cycle   <= 3'd0;
                    end else begin
                        instr  <= word;
                        pc_reg <= pc_reg + 32'd4;
                        cycle  <= 3'd0;
                    end
                end
            end
        end
    end

endmodule
